led_stretch: RTL and testbench
==============================

// Module: led_stretch
// PURPOSE
//  Output-side counterpart of the key debounce path: turns N single-cycle event
//  pulses (debounced key pulses or internal events) into visibly long LED flashes.
//  Each channel guarantees a minimum on-time and a minimum off-gap between flashes.
//  Requests that arrive during a flash are queued (one deep) and are never merged silently.
//  Sits between event sources and the board LED pins.
// PARAMETERS
//  N       4         number of independent channels
//  HOLD    1000000   LED on-time per flash, in clk cycles (>=1)
//  GAP     250000    forced LED off-time after each flash, in clk cycles (>=0)
//  RETRIG  0         1: a pulse during ON restarts the on-time; 0: the pulse is queued
//  CNT_W   24        counter width; must hold max(HOLD,GAP)
// PORTS
//  clk       in   1      system clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  pulse     in   N      per-channel event, one clk cycle wide; level is also accepted
//                        (each high cycle counts as one event)
//  led       out  N      registered LED drive, 1 = lit; led[i] is driven by pulse[i]
//  busy      out  N      1 while channel i is in ON or GAP
//  dropped   out  N      one-cycle flag: a channel-i event was discarded (queue full)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, cnt=0, pend=0; led=0, busy=0, dropped=0.
//    Reset mid-flash aborts the flash and clears any queued request.
//  Per-channel FSM, all outputs registered:
//  - IDLE: pulse=1 at edge t -> ON, cnt=HOLD-1; led=1 and busy=1 from cycle t+1.
//  - ON: led=1. cnt decrements each cycle.
//    - Pulse in ON, RETRIG=1: cnt reloads to HOLD-1; no queueing.
//    - Pulse in ON, RETRIG=0: pend<=1 if pend=0, else dropped=1 for one cycle.
//    - cnt==0 and GAP>0 -> GAP, cnt=GAP-1.
//    - cnt==0 and GAP==0 -> ON again (cnt=HOLD-1, pend<=0) if pend, else IDLE.
//    - With GAP==0, back-to-back flashes show no low cycle; this is intended.
//  - GAP: led=0, busy=1.
//    - Pulse in GAP: pend<=1 if pend=0, else dropped=1.
//    - cnt==0: if pend (including a pulse arriving in this same cycle) -> ON,
//      cnt=HOLD-1, pend<=0; else -> IDLE.
//  - Lit duration: exactly HOLD cycles. Off-gap: exactly GAP cycles.
//  - Pulse in the cycle a flash ends (ON, cnt==0): treated as arriving in ON
//    (queued/retriggered), never lost unless pend already set.
//  - Channels are fully independent; simultaneous pulses on any subset are legal.
//  - Counters never wrap: reload only on the transitions listed above.
//  - HOLD=1: a one-cycle flash. Illegal parameters (HOLD=0, CNT_W too small) are
//    flagged by an elaboration-time check.
// TESTING  (bench uses N=4, HOLD=4, GAP=2, RETRIG=0 unless noted)
//  1. Reset, then pulse[0] at cycle 10 -> led[0]=1 for cycles 11-14, busy[0]=1
//     for cycles 11-16, led=4'b0000 from cycle 15. Other channels stay 0.
//  2. pulse[1] at cycle 10 and again at cycle 12 -> flash at 11-14, gap at 15-16,
//     second flash at 17-20; dropped[1] never asserted.
//  3. pulse[2] at cycles 10, 12, 13 -> third pulse gives dropped[2]=1 at cycle 14;
//     exactly two flashes are produced.
//  4. RETRIG=1: pulse[3] at cycles 10 and 13 -> led[3]=1 continuously for
//     cycles 11-17, then a 2-cycle gap.
//  5. GAP=0: pulse[0] at cycles 10 and 11 -> led[0]=1 for cycles 11-18 with no
//     low cycle.
//  6. Async rst asserted at cycle 12 (mid-flash, with pend set) -> led, busy and
//     dropped go 0 immediately. After release, no queued flash appears and a
//     fresh pulse behaves as in scenario 1.

Source files
------------

// File: rtl/led_stretch.sv
// Per-channel LED pulse stretcher: each event pulse becomes a HOLD-cycle flash
// followed by a GAP-cycle forced off-time, with a one-deep request queue.
module led_stretch #(
  parameter int unsigned N      = 4,
  parameter int unsigned HOLD   = 1000000,
  parameter int unsigned GAP    = 250000,
  parameter int unsigned RETRIG = 0,
  parameter int unsigned CNT_W  = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pulse,
  output logic [N-1:0] led,
  output logic [N-1:0] busy,
  output logic [N-1:0] dropped
);

  localparam longint unsigned MAX_CNT = (64'd1 << CNT_W) - 64'd1;

  if (HOLD < 1) begin : g_bad_hold
    $error("led_stretch: HOLD must be >= 1");
  end
  if ((longint'(HOLD) - 1 > MAX_CNT) || (longint'(GAP) > MAX_CNT + 1)) begin : g_bad_width
    $error("led_stretch: CNT_W too small for HOLD/GAP");
  end

  localparam logic [CNT_W-1:0] C_HOLD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] C_GAP  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;
  localparam bit               RT     = (RETRIG != 0);
  localparam bit               HAS_GAP = (GAP > 0);

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_GAP} state_t;

  state_t           r_state     [N];
  logic [CNT_W-1:0] r_cnt       [N];
  logic [N-1:0]     r_pend;

  state_t           w_state_nxt [N];
  logic [CNT_W-1:0] w_cnt_nxt   [N];
  logic [N-1:0]     w_pend_nxt;
  logic [N-1:0]     w_drop_nxt;
  logic [N-1:0]     w_led_nxt;
  logic [N-1:0]     w_busy_nxt;

  always_comb begin
    w_pend_nxt = r_pend;
    w_drop_nxt = '0;
    w_led_nxt  = '0;
    w_busy_nxt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        ST_IDLE: begin
          if (pulse[i]) begin
            w_state_nxt[i] = ST_ON;
            w_cnt_nxt[i]   = C_HOLD;
          end
        end
        ST_ON: begin
          // Queue first, so a pulse on the final ON cycle is seen by the end-of-flash decision.
          if (pulse[i] && !RT) begin
            if (r_pend[i]) w_drop_nxt[i] = 1'b1;
            else           w_pend_nxt[i] = 1'b1;
          end
          if (pulse[i] && RT) begin
            w_cnt_nxt[i] = C_HOLD;
          end else if (r_cnt[i] != '0) begin
            w_cnt_nxt[i] = r_cnt[i] - 1'b1;
          end else if (HAS_GAP) begin
            w_state_nxt[i] = ST_GAP;
            w_cnt_nxt[i]   = C_GAP;
          end else if (w_pend_nxt[i]) begin
            w_cnt_nxt[i]  = C_HOLD;
            w_pend_nxt[i] = 1'b0;
          end else begin
            w_state_nxt[i] = ST_IDLE;
          end
        end
        ST_GAP: begin
          if (pulse[i]) begin
            if (r_pend[i]) w_drop_nxt[i] = 1'b1;
            else           w_pend_nxt[i] = 1'b1;
          end
          if (r_cnt[i] != '0) begin
            w_cnt_nxt[i] = r_cnt[i] - 1'b1;
          end else if (w_pend_nxt[i]) begin
            w_state_nxt[i] = ST_ON;
            w_cnt_nxt[i]   = C_HOLD;
            w_pend_nxt[i]  = 1'b0;
          end else begin
            w_state_nxt[i] = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt[i] = ST_IDLE;
          w_cnt_nxt[i]   = '0;
          w_pend_nxt[i]  = 1'b0;
        end
      endcase
      w_led_nxt[i]  = (w_state_nxt[i] == ST_ON);
      w_busy_nxt[i] = (w_state_nxt[i] != ST_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
      r_pend  <= '0;
      led     <= '0;
      busy    <= '0;
      dropped <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_pend  <= w_pend_nxt;
      led     <= w_led_nxt;
      busy    <= w_busy_nxt;
      dropped <= w_drop_nxt;
    end
  end

endmodule

// File: tb/tb_led_stretch.sv
// Directed bench for led_stretch: three instances cover RETRIG=0/GAP=2,
// RETRIG=1/GAP=2 and RETRIG=0/GAP=0, all with HOLD=4.
module tb_led_stretch;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] pa = '0, pb = '0, pc = '0;
  logic [3:0] la, ba, da, lb, bb, db, lc, bc, dc;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  led_stretch #(.N(4), .HOLD(4), .GAP(2), .RETRIG(0), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .pulse(pa), .led(la), .busy(ba), .dropped(da));
  led_stretch #(.N(4), .HOLD(4), .GAP(2), .RETRIG(1), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .pulse(pb), .led(lb), .busy(bb), .dropped(db));
  led_stretch #(.N(4), .HOLD(4), .GAP(0), .RETRIG(0), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .pulse(pc), .led(lc), .busy(bc), .dropped(dc));

  // Each loop step lands 1 ns into cycle c: outputs for cycle c are checked,
  // then the pulse for cycle c is driven (sampled at the edge that starts c+1).

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({la, ba, da, lb, bb, db, lc, bc, dc} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h required 0", {la, ba, da, lb, bb, db, lc, bc, dc});
    end
    #2 rst = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] el, eb;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      el = (c >= 11 && c <= 14) ? 4'b0001 : 4'b0000;
      eb = (c >= 11 && c <= 16) ? 4'b0001 : 4'b0000;
      n_checks++;
      if ({la, ba, da} !== {el, eb, 4'b0000}) begin
        n_fail++;
        $display("FAIL single c%0d: led/busy/drop got %b/%b/%b required %b/%b/0000", c, la, ba, da, el, eb);
      end
      pa = (c == 10) ? 4'b0001 : 4'b0000;
    end
  endtask

  task automatic test_queue();
    logic [3:0] el, eb;
    for (int c = 0; c < 26; c++) begin
      @(posedge clk); #1;
      el = ((c >= 11 && c <= 14) || (c >= 17 && c <= 20)) ? 4'b0010 : 4'b0000;
      eb = (c >= 11 && c <= 22) ? 4'b0010 : 4'b0000;
      n_checks++;
      if ({la, ba, da} !== {el, eb, 4'b0000}) begin
        n_fail++;
        $display("FAIL queue c%0d: led/busy/drop got %b/%b/%b required %b/%b/0000", c, la, ba, da, el, eb);
      end
      pa = (c == 10 || c == 12) ? 4'b0010 : 4'b0000;
    end
  endtask

  task automatic test_drop();
    logic [3:0] el, eb, ed;
    logic       prev = 1'b0;
    int         flashes = 0;
    for (int c = 0; c < 26; c++) begin
      @(posedge clk); #1;
      el = ((c >= 11 && c <= 14) || (c >= 17 && c <= 20)) ? 4'b0100 : 4'b0000;
      eb = (c >= 11 && c <= 22) ? 4'b0100 : 4'b0000;
      ed = (c == 14) ? 4'b0100 : 4'b0000;
      if (la[2] && !prev) flashes++;
      prev = la[2];
      n_checks++;
      if ({la, ba, da} !== {el, eb, ed}) begin
        n_fail++;
        $display("FAIL drop c%0d: led/busy/drop got %b/%b/%b required %b/%b/%b", c, la, ba, da, el, eb, ed);
      end
      pa = (c == 10 || c == 12 || c == 13) ? 4'b0100 : 4'b0000;
    end
    n_checks++;
    if (flashes !== 2) begin
      n_fail++;
      $display("FAIL drop_flash_count: got %0d required 2", flashes);
    end
  endtask

  task automatic test_retrig();
    logic [3:0] el, eb;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      el = (c >= 11 && c <= 17) ? 4'b1000 : 4'b0000;
      eb = (c >= 11 && c <= 19) ? 4'b1000 : 4'b0000;
      n_checks++;
      if ({lb, bb, db} !== {el, eb, 4'b0000}) begin
        n_fail++;
        $display("FAIL retrig c%0d: led/busy/drop got %b/%b/%b required %b/%b/0000", c, lb, bb, db, el, eb);
      end
      pb = (c == 10 || c == 13) ? 4'b1000 : 4'b0000;
    end
  endtask

  task automatic test_gap0();
    logic [3:0] el;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      el = (c >= 11 && c <= 18) ? 4'b0001 : 4'b0000;
      n_checks++;
      if ({lc, bc, dc} !== {el, el, 4'b0000}) begin
        n_fail++;
        $display("FAIL gap0 c%0d: led/busy/drop got %b/%b/%b required %b/%b/0000", c, lc, bc, dc, el, el);
      end
      pc = (c == 10 || c == 11) ? 4'b0001 : 4'b0000;
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] el, eb;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      el = (c >= 3 && c <= 6) ? 4'b1111 : 4'b0000;
      eb = (c >= 3 && c <= 8) ? 4'b1111 : 4'b0000;
      n_checks++;
      if ({la, ba, da} !== {el, eb, 4'b0000}) begin
        n_fail++;
        $display("FAIL simultaneous c%0d: led/busy/drop got %b/%b/%b required %b/%b/0000", c, la, ba, da, el, eb);
      end
      pa = (c == 2) ? 4'b1111 : 4'b0000;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] el, eb;
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 12) begin
        n_checks++;
        if ({la, ba} !== 8'b0001_0001) begin
          n_fail++;
          $display("FAIL rst_mid_pre: led/busy got %b/%b required 0001/0001", la, ba);
        end
      end
      pa = (c == 10 || c == 11) ? 4'b0001 : 4'b0000;
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({la, ba, da} !== 12'd0) begin
      n_fail++;
      $display("FAIL rst_mid_async: led/busy/drop got %b/%b/%b required 0", la, ba, da);
    end
    @(posedge clk); #3 rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      el = (c >= 11 && c <= 14) ? 4'b0001 : 4'b0000;
      eb = (c >= 11 && c <= 16) ? 4'b0001 : 4'b0000;
      n_checks++;
      if ({la, ba, da} !== {el, eb, 4'b0000}) begin
        n_fail++;
        $display("FAIL rst_mid_after c%0d: led/busy/drop got %b/%b/%b required %b/%b/0000", c, la, ba, da, el, eb);
      end
      pa = (c == 10) ? 4'b0001 : 4'b0000;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_queue();
    test_drop();
    test_retrig();
    test_gap0();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
